mc_ctrl_v2: RTL and testbench
=============================

# mc_ctrl_v2

Parametrised multi-cycle control unit for the MIPS datapath; successor to the current fixed FSM. It adds native sub-word loads and stores, a bounded memory handshake with timeout, and precise traps with a cause code. It sits between the instruction register / ALU flags and the datapath muxes, PC and memory interface.

## Interface
- `MEM_TIMEOUT`, 16: maximum wait cycles for `mem_ready` before a bus trap (≥2).
- `TRAP_ON_OVF`, 1: when 1, signed add/sub overflow traps; when 0, overflow is ignored.
- `SUBWORD_EN`, 1: when 1, lb/lbu/lh/lhu/sb/sh are legal; when 0, they are treated as illegal opcodes.
- Reset: one clock; reset is asynchronous and active-low.
- `clk` in 1: rising-edge clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `inst` in 32: instruction register contents.
- `mem_ready` in 1: memory handshake completes in this cycle.
- `zero`, `overflow` in 1 each: ALU flags.
- `pc_write`, `pc_write_cond`, `beq`, `iord`, `ir_write`, `reg_write` out 1 each: datapath strobes and selects.
- `mem_req`, `mem_we` out 1 each: memory request and write enable.
- `mem_size` out 2: 00 byte, 01 half, 10 word.
- `mem_sext` out 1: sign-extend load data.
- `mem_to_reg`, `pc_source`, `alu_src_a`, `alu_src_b`, `reg_dst` out 2 each: mux selects. `pc_source` 11 selects the trap vector.
- `alu_op` out 4: ADD 0010, SUB 0110, AND 0000, OR 0001, XOR 0011, NOR 0100, SLT 0111, SLTU 1011, SRL 0101, SLL 1000, ADDU 1001, SUBU 1010.
- `exc_valid` out 1: high for the single TRAP cycle.
- `exc_cause` out 2: 01 illegal, 10 overflow, 11 bus timeout. Holds its value until the next trap.
- `state_out` out 5: current state encoding.

## Operation
- States: IF 0, ID 1, EX_R 2, EX_I 3, EX_MEM 4, MEM_RD 5, MEM_WR 6, WB_R 7, WB_I 8, WB_LD 9, WB_LUI 10, EX_BR 11, EX_J 12, EX_JR 13, EX_JAL 14, TRAP 15.
- All outputs are a Moore decode of the state register, plus `mem_ready` gating of `ir_write`/`pc_write` in IF.
- IF:
  - `mem_req=1`, `iord=0`, `alu_src_a=00`, `alu_src_b=01`, ADD, `mem_size=10`.
  - `ir_write` and `pc_write` follow `mem_ready`.
  - Moves to ID on `mem_ready`.
- ID decodes `inst[31:26]`, and `inst[5:0]` for R-type:
  - R-type → EX_R; jr (funct 001000) → EX_JR.
  - Immediate ALU ops → EX_I; lui → WB_LUI.
  - Loads/stores → EX_MEM; beq/bne → EX_BR with `beq` 1/0; j → EX_J; jal → EX_JAL.
  - Any other opcode or funct → TRAP, cause 01.
- Store sizes: sb size 00, sh 01, sw 10.
- Load sizes: lb/lh/lw assert `mem_sext=1`; lbu/lhu deassert it.
- EX_MEM computes the address, then → MEM_RD (loads) or MEM_WR (stores).
- MEM_RD/MEM_WR hold `mem_req=1`, `iord=1` (plus `mem_we` for MEM_WR) until `mem_ready`. Then MEM_RD → WB_LD and MEM_WR → IF.
- EX_R/EX_I with signed ADD/SUB, `overflow=1` and `TRAP_ON_OVF=1` → TRAP, cause 10. No writeback stage is entered.
- TRAP asserts `exc_valid=1`, `pc_write=1`, `pc_source=11`, then → IF.
- Every WB_* state and EX_BR/EX_J/EX_JR/EX_JAL return to IF.

## Timing
- Reset state is IF, with `exc_cause=00`, `alu_op=ADD` and `mem_req=1`. All other strobes are 0. `ir_write`/`pc_write` follow `mem_ready` immediately after reset.
- Zero-wait latencies:
  - R and immediate ALU ops: 4 cycles (IF, ID, EX, WB).
  - Load: 5 cycles. Store: 4 cycles.
  - Branch, jump, lui: 3 cycles.
- Each wait cycle adds one cycle. The wait counter is cleared on entering IF/MEM_RD/MEM_WR and on `mem_ready`.
- Timeout: when the counter reaches `MEM_TIMEOUT-1` with `mem_ready` low, the FSM moves to TRAP with cause 11. If `mem_ready` arrives in that same cycle, the handshake wins.
- `reset_n` low mid-operation (e.g. in MEM_WR) drops `mem_req`/`mem_we` asynchronously. The FSM restarts at IF.

## Structure
- Shared package `mc_pkg`: state encodings, ALU op codes, opcode/funct constants, `mem_size` and cause codes.
- One sub-module, `mc_wait_timer`: width `$clog2(MEM_TIMEOUT)`, with clear, enable and `expired` output.
- Decode is a function in the top module.

## Test plan
- add (funct 100000), `mem_ready` tied to 1 → `state_out` 0,1,2,7,0; `reg_write=1` only in WB_R; `alu_op=0010`.
- lhu with 3 wait cycles in MEM_RD → 3 extra cycles in state 5 with `mem_req=1`, `mem_size=01`, `mem_sext=0`, then WB_LD.
- Opcode 6'b111111 → TRAP in 3rd cycle, `exc_valid=1` for one cycle, `exc_cause=01`, `pc_source=11`.
- sb with `mem_ready` held low, `MEM_TIMEOUT=4` → TRAP after 4 cycles in MEM_WR, cause 11.
- addi with `overflow=1` → TRAP, cause 10, `reg_write` never asserted. Repeat with `TRAP_ON_OVF=0` → WB_I normally.
- Pulse `reset_n` low during MEM_WR → `mem_we=0` the same cycle; `state_out=0` after release.

Source files
------------

// File: rtl/mc_pkg.sv
// Shared constants for the multi-cycle MIPS control unit: state encodings,
// ALU operation codes, opcode/funct values, memory sizes, trap causes and
// the decode result record.
package mc_pkg;

    localparam logic [4:0] S_IF     = 5'd0;
    localparam logic [4:0] S_ID     = 5'd1;
    localparam logic [4:0] S_EX_R   = 5'd2;
    localparam logic [4:0] S_EX_I   = 5'd3;
    localparam logic [4:0] S_EX_MEM = 5'd4;
    localparam logic [4:0] S_MEM_RD = 5'd5;
    localparam logic [4:0] S_MEM_WR = 5'd6;
    localparam logic [4:0] S_WB_R   = 5'd7;
    localparam logic [4:0] S_WB_I   = 5'd8;
    localparam logic [4:0] S_WB_LD  = 5'd9;
    localparam logic [4:0] S_WB_LUI = 5'd10;
    localparam logic [4:0] S_EX_BR  = 5'd11;
    localparam logic [4:0] S_EX_J   = 5'd12;
    localparam logic [4:0] S_EX_JR  = 5'd13;
    localparam logic [4:0] S_EX_JAL = 5'd14;
    localparam logic [4:0] S_TRAP   = 5'd15;

    localparam logic [3:0] ALU_AND  = 4'b0000;
    localparam logic [3:0] ALU_OR   = 4'b0001;
    localparam logic [3:0] ALU_ADD  = 4'b0010;
    localparam logic [3:0] ALU_XOR  = 4'b0011;
    localparam logic [3:0] ALU_NOR  = 4'b0100;
    localparam logic [3:0] ALU_SRL  = 4'b0101;
    localparam logic [3:0] ALU_SUB  = 4'b0110;
    localparam logic [3:0] ALU_SLT  = 4'b0111;
    localparam logic [3:0] ALU_SLL  = 4'b1000;
    localparam logic [3:0] ALU_ADDU = 4'b1001;
    localparam logic [3:0] ALU_SUBU = 4'b1010;
    localparam logic [3:0] ALU_SLTU = 4'b1011;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ADDIU = 6'b001001;
    localparam logic [5:0] OP_SLTI  = 6'b001010;
    localparam logic [5:0] OP_SLTIU = 6'b001011;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_ORI   = 6'b001101;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_LUI   = 6'b001111;
    localparam logic [5:0] OP_LB    = 6'b100000;
    localparam logic [5:0] OP_LH    = 6'b100001;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_LBU   = 6'b100100;
    localparam logic [5:0] OP_LHU   = 6'b100101;
    localparam logic [5:0] OP_SB    = 6'b101000;
    localparam logic [5:0] OP_SH    = 6'b101001;
    localparam logic [5:0] OP_SW    = 6'b101011;

    localparam logic [5:0] FN_SLL  = 6'b000000;
    localparam logic [5:0] FN_SRL  = 6'b000010;
    localparam logic [5:0] FN_JR   = 6'b001000;
    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_ADDU = 6'b100001;
    localparam logic [5:0] FN_SUB  = 6'b100010;
    localparam logic [5:0] FN_SUBU = 6'b100011;
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_XOR  = 6'b100110;
    localparam logic [5:0] FN_NOR  = 6'b100111;
    localparam logic [5:0] FN_SLT  = 6'b101010;
    localparam logic [5:0] FN_SLTU = 6'b101011;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    localparam logic [1:0] CAUSE_NONE    = 2'b00;
    localparam logic [1:0] CAUSE_ILLEGAL = 2'b01;
    localparam logic [1:0] CAUSE_OVF     = 2'b10;
    localparam logic [1:0] CAUSE_BUS     = 2'b11;

    // next: state entered from ID (S_TRAP marks an illegal instruction)
    typedef struct packed {
        logic [4:0] next;
        logic [3:0] alu_op;
        logic       ovf_chk;
        logic       store;
        logic [1:0] size;
        logic       sext;
        logic       beq;
    } dec_t;

endpackage

// File: rtl/mc_wait_timer.sv
// Memory handshake watchdog. Down-counter reloaded with TIMEOUT-1 on clear,
// decremented while enabled; expired is the terminal count (zero).
// Ports: clk, reset_n (async, active-low), clear, enable -> expired.
module mc_wait_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic reset_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);
    localparam int W = $clog2(TIMEOUT);
    localparam logic [W-1:0] LOAD = W'(TIMEOUT - 1);

    logic [W-1:0] count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= LOAD;
        end else if (clear) begin
            count <= LOAD;
        end else if (enable && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign expired = (count == '0);

endmodule

// File: rtl/mc_ctrl_v2.sv
// Multi-cycle MIPS control unit with sub-word memory access, a bounded
// memory handshake and precise traps.
// Inputs : clk, reset_n (async, active-low), inst (IR), mem_ready, zero,
//          overflow (ALU flags).
// Outputs: datapath strobes (pc_write, pc_write_cond, beq, iord, ir_write,
//          reg_write), memory interface (mem_req, mem_we, mem_size,
//          mem_sext), mux selects (mem_to_reg, pc_source, alu_src_a,
//          alu_src_b, reg_dst), alu_op, exc_valid/exc_cause, state_out.
//
// state  | meaning
// IF     | fetch, wait for mem_ready, PC+4
// ID     | decode, branch target in ALU
// EX_R   | R-type ALU op
// EX_I   | immediate ALU op
// EX_MEM | load/store address
// MEM_RD | load handshake
// MEM_WR | store handshake
// WB_R   | write rd from ALU
// WB_I   | write rt from ALU
// WB_LD  | write rt from memory
// WB_LUI | write rt with upper immediate
// EX_BR  | beq/bne compare and conditional PC write
// EX_J   | jump
// EX_JR  | jump to rs
// EX_JAL | jump and link to $31
// TRAP   | PC <- trap vector, exc_valid pulse
module mc_ctrl_v2
    import mc_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int TRAP_ON_OVF = 1,
    parameter int SUBWORD_EN  = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [31:0] inst,
    input  logic        mem_ready,
    input  logic        zero,
    input  logic        overflow,
    output logic        pc_write,
    output logic        pc_write_cond,
    output logic        beq,
    output logic        iord,
    output logic        ir_write,
    output logic        reg_write,
    output logic        mem_req,
    output logic        mem_we,
    output logic [1:0]  mem_size,
    output logic        mem_sext,
    output logic [1:0]  mem_to_reg,
    output logic [1:0]  pc_source,
    output logic [1:0]  alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  reg_dst,
    output logic [3:0]  alu_op,
    output logic        exc_valid,
    output logic [1:0]  exc_cause,
    output logic [4:0]  state_out
);

    function automatic dec_t decode(input logic [5:0] op, input logic [5:0] fn,
                                    input logic sub_en);
        dec_t d;
        d.next    = S_TRAP;
        d.alu_op  = ALU_ADD;
        d.ovf_chk = 1'b0;
        d.store   = 1'b0;
        d.size    = SZ_WORD;
        d.sext    = 1'b0;
        d.beq     = 1'b0;
        case (op)
            OP_RTYPE: begin
                d.next = S_EX_R;
                case (fn)
                    FN_ADD:  begin d.alu_op = ALU_ADD; d.ovf_chk = 1'b1; end
                    FN_SUB:  begin d.alu_op = ALU_SUB; d.ovf_chk = 1'b1; end
                    FN_ADDU: d.alu_op = ALU_ADDU;
                    FN_SUBU: d.alu_op = ALU_SUBU;
                    FN_AND:  d.alu_op = ALU_AND;
                    FN_OR:   d.alu_op = ALU_OR;
                    FN_XOR:  d.alu_op = ALU_XOR;
                    FN_NOR:  d.alu_op = ALU_NOR;
                    FN_SLT:  d.alu_op = ALU_SLT;
                    FN_SLTU: d.alu_op = ALU_SLTU;
                    FN_SLL:  d.alu_op = ALU_SLL;
                    FN_SRL:  d.alu_op = ALU_SRL;
                    FN_JR:   d.next = S_EX_JR;
                    default: d.next = S_TRAP;
                endcase
            end
            OP_ADDI:  begin d.next = S_EX_I; d.ovf_chk = 1'b1; end
            OP_ADDIU: begin d.next = S_EX_I; d.alu_op = ALU_ADDU; end
            OP_SLTI:  begin d.next = S_EX_I; d.alu_op = ALU_SLT; end
            OP_SLTIU: begin d.next = S_EX_I; d.alu_op = ALU_SLTU; end
            OP_ANDI:  begin d.next = S_EX_I; d.alu_op = ALU_AND; end
            OP_ORI:   begin d.next = S_EX_I; d.alu_op = ALU_OR; end
            OP_XORI:  begin d.next = S_EX_I; d.alu_op = ALU_XOR; end
            OP_LUI:   d.next = S_WB_LUI;
            OP_LW:    begin d.next = S_EX_MEM; d.sext = 1'b1; end
            OP_SW:    begin d.next = S_EX_MEM; d.store = 1'b1; end
            OP_LB:    if (sub_en) begin d.next = S_EX_MEM; d.size = SZ_BYTE; d.sext = 1'b1; end
            OP_LBU:   if (sub_en) begin d.next = S_EX_MEM; d.size = SZ_BYTE; end
            OP_LH:    if (sub_en) begin d.next = S_EX_MEM; d.size = SZ_HALF; d.sext = 1'b1; end
            OP_LHU:   if (sub_en) begin d.next = S_EX_MEM; d.size = SZ_HALF; end
            OP_SB:    if (sub_en) begin d.next = S_EX_MEM; d.size = SZ_BYTE; d.store = 1'b1; end
            OP_SH:    if (sub_en) begin d.next = S_EX_MEM; d.size = SZ_HALF; d.store = 1'b1; end
            OP_BEQ:   begin d.next = S_EX_BR; d.alu_op = ALU_SUB; d.beq = 1'b1; end
            OP_BNE:   begin d.next = S_EX_BR; d.alu_op = ALU_SUB; end
            OP_J:     d.next = S_EX_J;
            OP_JAL:   d.next = S_EX_JAL;
            default:  d.next = S_TRAP;
        endcase
        return d;
    endfunction

    logic [4:0] state, state_nxt;
    logic [1:0] cause_nxt;
    dec_t       dec;
    logic       in_wait, expired;
    logic       mem_req_s, mem_we_s;

    // zero is combined with pc_write_cond/beq in the datapath; the register
    // and immediate fields of inst are routed there directly.
    logic unused_bits;
    assign unused_bits = ^{zero, inst[25:6]};

    assign dec     = decode(inst[31:26], inst[5:0], SUBWORD_EN != 0);
    assign in_wait = (state == S_IF) || (state == S_MEM_RD) || (state == S_MEM_WR);

    mc_wait_timer #(.TIMEOUT(MEM_TIMEOUT)) u_wait_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .clear   (!in_wait || mem_ready),
        .enable  (in_wait && !mem_ready),
        .expired (expired)
    );

    always_comb begin
        state_nxt = state;
        cause_nxt = exc_cause;
        case (state)
            S_IF, S_MEM_RD, S_MEM_WR: begin
                // A handshake arriving on the last allowed cycle beats the timeout.
                if (mem_ready) begin
                    state_nxt = (state == S_IF)     ? S_ID :
                                (state == S_MEM_RD) ? S_WB_LD : S_IF;
                end else if (expired) begin
                    state_nxt = S_TRAP;
                    cause_nxt = CAUSE_BUS;
                end
            end
            S_ID: begin
                state_nxt = dec.next;
                if (dec.next == S_TRAP) cause_nxt = CAUSE_ILLEGAL;
            end
            S_EX_R, S_EX_I: begin
                if ((TRAP_ON_OVF != 0) && dec.ovf_chk && overflow) begin
                    state_nxt = S_TRAP;
                    cause_nxt = CAUSE_OVF;
                end else begin
                    state_nxt = (state == S_EX_R) ? S_WB_R : S_WB_I;
                end
            end
            S_EX_MEM: state_nxt = dec.store ? S_MEM_WR : S_MEM_RD;
            default:  state_nxt = S_IF;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= S_IF;
            exc_cause <= CAUSE_NONE;
        end else begin
            state     <= state_nxt;
            exc_cause <= cause_nxt;
        end
    end

    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        beq           = 1'b0;
        iord          = 1'b0;
        ir_write      = 1'b0;
        reg_write     = 1'b0;
        mem_req_s     = 1'b0;
        mem_we_s      = 1'b0;
        mem_size      = SZ_WORD;
        mem_sext      = 1'b0;
        mem_to_reg    = 2'b00;
        pc_source     = 2'b00;
        alu_src_a     = 2'b00;
        alu_src_b     = 2'b00;
        reg_dst       = 2'b00;
        alu_op        = ALU_ADD;
        exc_valid     = 1'b0;
        case (state)
            S_IF: begin
                mem_req_s = 1'b1;
                alu_src_b = 2'b01;
                ir_write  = mem_ready;
                pc_write  = mem_ready;
            end
            S_ID:     alu_src_b = 2'b11;
            S_EX_R:   begin alu_src_a = 2'b01; alu_op = dec.alu_op; end
            S_EX_I:   begin alu_src_a = 2'b01; alu_src_b = 2'b10; alu_op = dec.alu_op; end
            S_EX_MEM: begin alu_src_a = 2'b01; alu_src_b = 2'b10; end
            S_MEM_RD: begin
                mem_req_s = 1'b1; iord = 1'b1; mem_size = dec.size; mem_sext = dec.sext;
            end
            S_MEM_WR: begin
                mem_req_s = 1'b1; iord = 1'b1; mem_we_s = 1'b1; mem_size = dec.size;
            end
            S_WB_R:   begin reg_write = 1'b1; reg_dst = 2'b01; end
            S_WB_I:   reg_write = 1'b1;
            S_WB_LD:  begin
                reg_write = 1'b1; mem_to_reg = 2'b01; mem_size = dec.size; mem_sext = dec.sext;
            end
            S_WB_LUI: begin reg_write = 1'b1; mem_to_reg = 2'b10; end
            S_EX_BR:  begin
                alu_src_a = 2'b01; alu_op = ALU_SUB; pc_write_cond = 1'b1;
                pc_source = 2'b01; beq = dec.beq;
            end
            S_EX_J:   begin pc_write = 1'b1; pc_source = 2'b10; end
            // jr encodes rt=$0, so rs + rt through the ALU is rs.
            S_EX_JR:  begin pc_write = 1'b1; alu_src_a = 2'b01; end
            S_EX_JAL: begin
                pc_write = 1'b1; pc_source = 2'b10; reg_write = 1'b1;
                reg_dst = 2'b10; mem_to_reg = 2'b11;
            end
            S_TRAP:   begin exc_valid = 1'b1; pc_write = 1'b1; pc_source = 2'b11; end
            default:  ;
        endcase
    end

    // Memory strobes drop the moment reset asserts, not at the next edge.
    assign mem_req   = mem_req_s & reset_n;
    assign mem_we    = mem_we_s & reset_n;
    assign state_out = state;

endmodule

// File: tb/tb_mc_ctrl_v2.sv
module tb_mc_ctrl_v2;

    logic        clk, reset_n, mem_ready, zero, overflow;
    logic [31:0] inst;

    logic        a_pc_write, a_pc_write_cond, a_beq, a_iord, a_ir_write, a_reg_write;
    logic        a_mem_req, a_mem_we, a_mem_sext, a_exc_valid;
    logic [1:0]  a_mem_size, a_mem_to_reg, a_pc_source, a_alu_src_a, a_alu_src_b, a_reg_dst, a_exc_cause;
    logic [3:0]  a_alu_op;
    logic [4:0]  a_state;

    logic        b_pc_write, b_pc_write_cond, b_beq, b_iord, b_ir_write, b_reg_write;
    logic        b_mem_req, b_mem_we, b_mem_sext, b_exc_valid;
    logic [1:0]  b_mem_size, b_mem_to_reg, b_pc_source, b_alu_src_a, b_alu_src_b, b_reg_dst, b_exc_cause;
    logic [3:0]  b_alu_op;
    logic [4:0]  b_state;

    int n_tests = 0;
    int n_fail  = 0;

    localparam logic [31:0] I_ADD  = 32'h00221820;
    localparam logic [31:0] I_LHU  = 32'h94220004;
    localparam logic [31:0] I_BAD  = 32'hFC000000;
    localparam logic [31:0] I_SB   = 32'hA0220000;
    localparam logic [31:0] I_ADDI = 32'h20220001;
    localparam logic [31:0] I_SW   = 32'hAC220000;
    localparam logic [31:0] I_BEQ  = 32'h10220003;

    mc_ctrl_v2 #(.MEM_TIMEOUT(4), .TRAP_ON_OVF(1), .SUBWORD_EN(1)) dut_a (
        .clk(clk), .reset_n(reset_n), .inst(inst), .mem_ready(mem_ready),
        .zero(zero), .overflow(overflow),
        .pc_write(a_pc_write), .pc_write_cond(a_pc_write_cond), .beq(a_beq),
        .iord(a_iord), .ir_write(a_ir_write), .reg_write(a_reg_write),
        .mem_req(a_mem_req), .mem_we(a_mem_we), .mem_size(a_mem_size),
        .mem_sext(a_mem_sext), .mem_to_reg(a_mem_to_reg), .pc_source(a_pc_source),
        .alu_src_a(a_alu_src_a), .alu_src_b(a_alu_src_b), .reg_dst(a_reg_dst),
        .alu_op(a_alu_op), .exc_valid(a_exc_valid), .exc_cause(a_exc_cause),
        .state_out(a_state)
    );

    mc_ctrl_v2 #(.MEM_TIMEOUT(4), .TRAP_ON_OVF(0), .SUBWORD_EN(0)) dut_b (
        .clk(clk), .reset_n(reset_n), .inst(inst), .mem_ready(mem_ready),
        .zero(zero), .overflow(overflow),
        .pc_write(b_pc_write), .pc_write_cond(b_pc_write_cond), .beq(b_beq),
        .iord(b_iord), .ir_write(b_ir_write), .reg_write(b_reg_write),
        .mem_req(b_mem_req), .mem_we(b_mem_we), .mem_size(b_mem_size),
        .mem_sext(b_mem_sext), .mem_to_reg(b_mem_to_reg), .pc_source(b_pc_source),
        .alu_src_a(b_alu_src_a), .alu_src_b(b_alu_src_b), .reg_dst(b_reg_dst),
        .alu_op(b_alu_op), .exc_valid(b_exc_valid), .exc_cause(b_exc_cause),
        .state_out(b_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Starts at posedge+1 with reset asserted; returns at posedge+3 in IF.
    task automatic do_reset(input logic [31:0] ins, input logic rdy);
        @(posedge clk);
        #1;
        inst      = ins;
        mem_ready = rdy;
        reset_n   = 1'b0;
        #1;
        reset_n   = 1'b1;
        #1;
    endtask

    // Advance one clock; set mem_ready for the new cycle; return settled.
    task automatic nxt(input logic rdy);
        @(posedge clk);
        #1;
        mem_ready = rdy;
        #2;
    endtask

    initial begin
        reset_n   = 1'b0;
        inst      = 32'h0;
        mem_ready = 1'b0;
        zero      = 1'b0;
        overflow  = 1'b0;

        // Reset state, then add with zero-wait memory
        do_reset(I_ADD, 1'b0);
        chk("rst_state",     32'(a_state),     32'd0);
        chk("rst_mem_req",   32'(a_mem_req),   32'd1);
        chk("rst_alu_op",    32'(a_alu_op),    32'h2);
        chk("rst_cause",     32'(a_exc_cause), 32'd0);
        chk("rst_ir_write",  32'(a_ir_write),  32'd0);
        chk("rst_pc_write",  32'(a_pc_write),  32'd0);
        chk("rst_reg_write", 32'(a_reg_write), 32'd0);
        chk("rst_mem_size",  32'(a_mem_size),  32'h2);
        mem_ready = 1'b1;
        #1;
        chk("if_ir_write",   32'(a_ir_write),  32'd1);
        chk("if_pc_write",   32'(a_pc_write),  32'd1);
        nxt(1'b1);
        chk("add_id",        32'(a_state),     32'd1);
        chk("add_id_rw",     32'(a_reg_write), 32'd0);
        nxt(1'b1);
        chk("add_ex",        32'(a_state),     32'd2);
        chk("add_alu_op",    32'(a_alu_op),    32'h2);
        chk("add_ex_rw",     32'(a_reg_write), 32'd0);
        nxt(1'b1);
        chk("add_wb",        32'(a_state),     32'd7);
        chk("add_wb_rw",     32'(a_reg_write), 32'd1);
        nxt(1'b1);
        chk("add_done",      32'(a_state),     32'd0);
        chk("add_done_rw",   32'(a_reg_write), 32'd0);

        // lhu with three wait cycles; the fourth cycle is the last one before
        // timeout and its handshake must win
        do_reset(I_LHU, 1'b1);
        nxt(1'b1);
        nxt(1'b1);
        chk("lhu_exmem",     32'(a_state),     32'd4);
        for (int i = 0; i < 3; i++) begin
            nxt(1'b0);
            chk("lhu_wait_st",   32'(a_state),    32'd5);
            chk("lhu_wait_req",  32'(a_mem_req),  32'd1);
            chk("lhu_wait_size", 32'(a_mem_size), 32'h1);
            chk("lhu_wait_sext", 32'(a_mem_sext), 32'd0);
        end
        nxt(1'b1);
        chk("lhu_rd_last",   32'(a_state),     32'd5);
        chk("lhu_iord",      32'(a_iord),      32'd1);
        nxt(1'b1);
        chk("lhu_wbld",      32'(a_state),     32'd9);
        chk("lhu_wbld_m2r",  32'(a_mem_to_reg),32'h1);
        nxt(1'b1);
        chk("lhu_done",      32'(a_state),     32'd0);

        // Illegal opcode
        do_reset(I_BAD, 1'b1);
        nxt(1'b1);
        chk("ill_id_exc",    32'(a_exc_valid), 32'd0);
        nxt(1'b1);
        chk("ill_trap",      32'(a_state),     32'd15);
        chk("ill_exc_valid", 32'(a_exc_valid), 32'd1);
        chk("ill_cause",     32'(a_exc_cause), 32'h1);
        chk("ill_pc_src",    32'(a_pc_source), 32'h3);
        chk("ill_pc_write",  32'(a_pc_write),  32'd1);
        nxt(1'b1);
        chk("ill_back_if",   32'(a_state),     32'd0);
        chk("ill_exc_pulse", 32'(a_exc_valid), 32'd0);
        chk("ill_cause_hold",32'(a_exc_cause), 32'h1);

        // sb with memory never ready: four MEM_WR cycles then bus trap;
        // the subword-disabled instance traps it as illegal from ID
        do_reset(I_SB, 1'b1);
        chk("sb_rst_cause",  32'(a_exc_cause), 32'd0);
        nxt(1'b1);
        nxt(1'b1);
        chk("sb_b_illegal",  32'(b_state),     32'd15);
        chk("sb_b_cause",    32'(b_exc_cause), 32'h1);
        for (int i = 0; i < 4; i++) begin
            nxt(1'b0);
            chk("sb_wr_st",   32'(a_state),    32'd6);
            chk("sb_wr_we",   32'(a_mem_we),   32'd1);
            chk("sb_wr_size", 32'(a_mem_size), 32'h0);
        end
        nxt(1'b0);
        chk("sb_timeout",    32'(a_state),     32'd15);
        chk("sb_cause",      32'(a_exc_cause), 32'h3);
        chk("sb_trap_we",    32'(a_mem_we),    32'd0);

        // addi overflow: trapping instance vs. ignoring instance
        overflow = 1'b1;
        do_reset(I_ADDI, 1'b1);
        nxt(1'b1);
        nxt(1'b1);
        chk("ovf_exi",       32'(a_state),     32'd3);
        chk("ovf_exi_rw",    32'(a_reg_write), 32'd0);
        nxt(1'b1);
        chk("ovf_trap",      32'(a_state),     32'd15);
        chk("ovf_cause",     32'(a_exc_cause), 32'h2);
        chk("ovf_trap_rw",   32'(a_reg_write), 32'd0);
        chk("ovf_b_wbi",     32'(b_state),     32'd8);
        chk("ovf_b_rw",      32'(b_reg_write), 32'd1);
        nxt(1'b1);
        chk("ovf_back_if",   32'(a_state),     32'd0);
        overflow = 1'b0;

        // beq: three cycles
        do_reset(I_BEQ, 1'b1);
        nxt(1'b1);
        nxt(1'b1);
        chk("beq_st",        32'(a_state),         32'd11);
        chk("beq_flag",      32'(a_beq),           32'd1);
        chk("beq_cond",      32'(a_pc_write_cond), 32'd1);
        chk("beq_alu",       32'(a_alu_op),        32'h6);
        nxt(1'b1);
        chk("beq_done",      32'(a_state),         32'd0);

        // Asynchronous reset in the middle of a store
        do_reset(I_SW, 1'b1);
        nxt(1'b1);
        nxt(1'b1);
        nxt(1'b0);
        chk("sw_wr_st",      32'(a_state),     32'd6);
        chk("sw_wr_we",      32'(a_mem_we),    32'd1);
        reset_n = 1'b0;
        #1;
        chk("arst_we",       32'(a_mem_we),    32'd0);
        chk("arst_req",      32'(a_mem_req),   32'd0);
        reset_n = 1'b1;
        #1;
        chk("arst_state",    32'(a_state),     32'd0);
        chk("arst_we_rel",   32'(a_mem_we),    32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
